// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one common data bus among NREQ execution units.
// Define CDB_PERF_CNT_EN to build the grant/conflict performance counters.
module cdb_arbiter #(
    parameter int unsigned NREQ = 6,
    parameter int unsigned DW   = 32,
    parameter int unsigned TW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ*TW-1:0] req_tag,
    output logic [NREQ-1:0]   req_ready,
    output logic              cdb_valid,
    output logic [DW-1:0]     cdb_data,
    output logic [TW-1:0]     cdb_tag,
    output logic [2:0]        cdb_src,
    input  logic              perf_clr,
    output logic [31:0]       perf_grant_cnt,
    output logic [31:0]       perf_conflict_cnt
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            cdb_valid_q, cdb_valid_d;
    logic [DW-1:0]   cdb_data_q, cdb_data_d;
    logic [TW-1:0]   cdb_tag_q, cdb_tag_d;
    logic [2:0]      cdb_src_q, cdb_src_d;
    logic [NREQ-1:0] gnt;
    logic            gnt_any;
    logic [PW-1:0]   win;

    // Search ptr, ptr+1, ... with wrap; reset and flush suppress every grant.
    always_comb begin : arb
        int unsigned idx;
        gnt     = '0;
        gnt_any = 1'b0;
        win     = '0;
        idx     = 0;
        if (!rst && !flush) begin
            for (int unsigned off = 0; off < NREQ; off++) begin
                idx = 32'(ptr_q) + off;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!gnt_any && req_valid[PW'(idx)]) begin
                    gnt_any = 1'b1;
                    win     = PW'(idx);
                end
            end
        end
        if (gnt_any) gnt[win] = 1'b1;
    end

    always_comb begin
        ptr_d       = ptr_q;
        cdb_valid_d = gnt_any;
        cdb_data_d  = cdb_data_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_src_d   = cdb_src_q;
        if (gnt_any) begin
            ptr_d      = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            cdb_src_d  = 3'(win);
            cdb_data_d = '0;
            cdb_tag_d  = '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    cdb_data_d = req_data[i*DW +: DW];
                    cdb_tag_d  = req_tag[i*TW +: TW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // A broadcast still in flight when reset arrives is discarded, not presented.
    assign cdb_valid = cdb_valid_q & ~rst;
    assign cdb_data  = cdb_data_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_src   = cdb_src_q;
    assign req_ready = gnt;

`ifdef CDB_PERF_CNT_EN
    logic [31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0] conf_cnt_q, conf_cnt_d;
    logic        conflict;

    always_comb begin
        conflict    = !flush && ($countones(req_valid) >= 2);
        grant_cnt_d = grant_cnt_q;
        conf_cnt_d  = conf_cnt_q;
        if (perf_clr) begin
            grant_cnt_d = '0;
            conf_cnt_d  = '0;
        end else begin
            if (gnt_any && grant_cnt_q != '1) grant_cnt_d = grant_cnt_q + 32'd1;
            if (conflict && conf_cnt_q != '1) conf_cnt_d = conf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
            conf_cnt_q  <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            conf_cnt_q  <= conf_cnt_d;
        end
    end

    assign perf_grant_cnt    = grant_cnt_q;
    assign perf_conflict_cnt = conf_cnt_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr   = perf_clr;
    assign perf_grant_cnt    = '0;
    assign perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios then randomized traffic
// compared against a distance-based round-robin reference model.
module tb_cdb_arbiter;
    localparam int NREQ = 6;
    localparam int DW   = 32;
    localparam int TW   = 4;
`ifdef CDB_PERF_CNT_EN
    localparam logic [31:0] P10 = 32'd10;
`else
    localparam logic [31:0] P10 = 32'd0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, flush, perf_clr;
    logic [NREQ-1:0]      vld;
    logic [DW-1:0]        dat [NREQ];
    logic [TW-1:0]        tg  [NREQ];
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ*TW-1:0]   req_tag;
    logic [NREQ-1:0]      req_ready;
    logic                 cdb_valid;
    logic [DW-1:0]        cdb_data;
    logic [TW-1:0]        cdb_tag;
    logic [2:0]           cdb_src;
    logic [31:0]          perf_grant_cnt, perf_conflict_cnt;

    always_comb begin
        req_data = '0;
        req_tag  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DW +: DW] = dat[i];
            req_tag[i*TW +: TW]  = tg[i];
        end
    end

    cdb_arbiter #(.NREQ(NREQ), .DW(DW), .TW(TW)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .req_valid         (vld),
        .req_data          (req_data),
        .req_tag           (req_tag),
        .req_ready         (req_ready),
        .cdb_valid         (cdb_valid),
        .cdb_data          (cdb_data),
        .cdb_tag           (cdb_tag),
        .cdb_src           (cdb_src),
        .perf_clr          (perf_clr),
        .perf_grant_cnt    (perf_grant_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          m_ptr;
    logic        m_cv;
    logic [DW-1:0] m_cd;
    logic [TW-1:0] m_ct;
    logic [2:0]  m_cs;
    logic [31:0] m_gc, m_cc;
    int          last_w;
    int          seen [NREQ];
    int          seen_total;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Winner = valid unit at the smallest circular distance from the pointer.
    function automatic int winner();
        int best = -1;
        int bd = NREQ;
        if (rst || flush) return -1;
        for (int i = 0; i < NREQ; i++) begin
            if (vld[i]) begin
                int d = (i - m_ptr + NREQ) % NREQ;
                if (d < bd) begin
                    bd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cv = 1'b0; m_cd = '0; m_ct = '0; m_cs = '0; m_gc = '0; m_cc = '0;
    endtask

    task automatic cyc();
        int w;
        logic [NREQ-1:0] er;
        @(negedge clk);
        w  = winner();
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        check("cdb_valid", 64'(cdb_valid), 64'(m_cv && !rst));
        check("cdb_data", 64'(cdb_data), 64'(m_cd));
        check("cdb_tag", 64'(cdb_tag), 64'(m_ct));
        check("cdb_src", 64'(cdb_src), 64'(m_cs));
        check("perf_grant", 64'(perf_grant_cnt), 64'(m_gc));
        check("perf_conflict", 64'(perf_conflict_cnt), 64'(m_cc));
        if (cdb_valid === 1'b1 && cdb_src < 3'(NREQ)) begin
            seen[int'(cdb_src)]++;
            seen_total++;
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_cv = (w >= 0);
            if (w >= 0) begin
                m_cd  = dat[w];
                m_ct  = tg[w];
                m_cs  = 3'(w);
                m_ptr = (w + 1) % NREQ;
            end
`ifdef CDB_PERF_CNT_EN
            if (perf_clr) begin
                m_gc = '0;
                m_cc = '0;
            end else begin
                if (w >= 0 && m_gc != 32'hFFFF_FFFF) m_gc = m_gc + 32'd1;
                if (!flush && $countones(vld) >= 2 && m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 32'd1;
            end
`endif
        end
        last_w = w;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; perf_clr = 1'b0; vld = '0;
        for (int i = 0; i < NREQ; i++) begin dat[i] = '0; tg[i] = '0; seen[i] = 0; end
        seen_total = 0;
        last_w = -1;
        model_reset();
        @(posedge clk); #1;

        // Reset with all units requesting: no grants, outputs cleared
        vld = '1;
        cyc(); cyc();
        rst = 1'b0; vld = '0;
        cyc();

        // Single requester, zero-latency grant and one-cycle broadcast
        vld = 6'b000001; dat[0] = 32'h0000_00AA; tg[0] = 4'h3;
        cyc();
        check("single_valid", 64'(cdb_valid), 64'(1));
        check("single_data", 64'(cdb_data), 64'h0000_00AA);
        check("single_tag", 64'(cdb_tag), 64'(3));
        check("single_src", 64'(cdb_src), 64'(0));
        vld = '0;
        cyc();

        // All six valid for 12 cycles: two full rotations
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            dat[i] = 32'h1000_0000 + 32'(i);
            tg[i]  = 4'(i + 8);
            seen[i] = 0;
        end
        seen_total = 0;
        vld = '1;
        repeat (12) cyc();
        vld = '0;
        cyc();
        for (int i = 0; i < NREQ; i++) check($sformatf("rot_seen%0d", i), 64'(seen[i]), 64'(2));
        check("rot_total", 64'(seen_total), 64'(12));

        // Pointer at 4 with units 1 and 4 valid
        rst = 1'b1; cyc(); rst = 1'b0;
        vld = 6'b001000; cyc();
        vld = 6'b010010; cyc();
        check("ptr4_first", 64'(cdb_src), 64'(4));
        vld = 6'b000010; cyc();
        check("ptr4_second", 64'(cdb_src), 64'(1));
        vld = '1; cyc();
        check("ptr4_then2", 64'(cdb_src), 64'(2));
        vld = '0; cyc();

        // Flush with units 0-2 valid, then release; then flush over a live broadcast
        rst = 1'b1; cyc(); rst = 1'b0;
        vld = 6'b000111; flush = 1'b1; cyc();
        check("flush_novalid", 64'(cdb_valid), 64'(0));
        flush = 1'b0; cyc();
        check("flush_after_src", 64'(cdb_src), 64'(0));
        flush = 1'b1; cyc();
        flush = 1'b0; vld = '0; cyc();

        // Reset in the cycle after a grant
        rst = 1'b1; cyc(); rst = 1'b0;
        vld = 6'b000100; dat[2] = 32'hDEAD_BEEF; cyc();
        rst = 1'b1; cyc();
        check("rst_mid_valid", 64'(cdb_valid), 64'(0));
        check("rst_mid_data", 64'(cdb_data), 64'(0));
        rst = 1'b0; cyc();
        vld = '0; cyc();

        // Performance counters: units 3 and 5 contending for 10 cycles
        perf_clr = 1'b1; cyc(); perf_clr = 1'b0;
        vld = 6'b101000;
        repeat (10) cyc();
        check("perf_grant10", 64'(perf_grant_cnt), 64'(P10));
        check("perf_conf10", 64'(perf_conflict_cnt), 64'(P10));
        vld = '0; perf_clr = 1'b1; cyc(); perf_clr = 1'b0;
        check("perf_clr_grant", 64'(perf_grant_cnt), 64'(0));
        check("perf_clr_conf", 64'(perf_conflict_cnt), 64'(0));
`ifdef CDB_PERF_CNT_EN
        force dut.grant_cnt_q = 32'hFFFF_FFFE;
        force dut.conf_cnt_q  = 32'hFFFF_FFFE;
        #1;
        release dut.grant_cnt_q;
        release dut.conf_cnt_q;
        m_gc = 32'hFFFF_FFFE; m_cc = 32'hFFFF_FFFE;
        vld = 6'b101000;
        repeat (4) cyc();
        check("perf_sat_grant", 64'(perf_grant_cnt), 64'hFFFF_FFFF);
        check("perf_sat_conf", 64'(perf_conflict_cnt), 64'hFFFF_FFFF);
        vld = '0; cyc();
`endif

        // Randomized traffic; requesters hold payload until granted
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_w == i || !vld[i]) begin
                    vld[i] = ($urandom_range(0, 2) != 0);
                    dat[i] = $urandom;
                    tg[i]  = 4'($urandom);
                end
            end
            flush    = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 49) == 0);
            perf_clr = ($urandom_range(0, 29) == 0);
            cyc();
        end
        rst = 1'b0; flush = 1'b0; perf_clr = 1'b0; vld = '0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-002 Parameter NREQ, default 6, gives the requester count (0-2 ADD1-3, 3-4 MUL1-2, 5 LS).
REQ-003 Parameter DW, default 32, gives the result width.
REQ-004 Parameter TW, default 4, gives the reservation-station tag width.
REQ-005 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  squash: no grant this cycle.
- req_valid  in  NREQ  per-unit result pending.
- req_data  in  NREQ*DW  per-unit result; slice i = [i*DW +: DW].
- req_tag  in  NREQ*TW  per-unit producing RS tag.
- req_ready  out  NREQ  one-hot grant / accept.
- cdb_valid  out  1  broadcast valid.
- cdb_data  out  DW  broadcast result.
- cdb_tag  out  TW  broadcast tag.
- cdb_src  out  3  index of the winning unit.
- perf_clr  in  1  clear performance counters.
- perf_grant_cnt  out  32  total grants.
- perf_conflict_cnt  out  32  cycles with two or more requests pending.

Function
REQ-006 The block SHALL share the single common data bus among NREQ execution units and grant at most one per cycle.
REQ-007 Arbitration SHALL be round-robin from a pointer ptr, searching ptr, ptr+1, ..., wrapping mod NREQ; the first valid index wins.
REQ-008 After a grant to index w, ptr SHALL become w+1, or 0 when w = NREQ-1; with no grant, ptr SHALL hold.
REQ-009 req_ready SHALL be combinational from req_valid, ptr and flush, and SHALL be one-hot or zero.
REQ-010 req_ready[i] SHALL only be asserted when req_valid[i] is 1.
REQ-011 A transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-012 A requester SHALL hold valid, data and tag stable until transfer; flush is the only allowed exception.
REQ-013 The winner's data, tag and index SHALL be registered onto cdb_* the next cycle (latency 1), with cdb_valid=1 for exactly one cycle per transfer.
REQ-014 Back-to-back grants SHALL give one broadcast per cycle (100% bus utilisation under load).
REQ-015 In a cycle with no transfer, cdb_valid SHALL be 0 and cdb_data, cdb_tag and cdb_src SHALL hold their previous values.
REQ-016 With flush=1: req_ready SHALL be all zeros, cdb_valid SHALL be 0 the next cycle, and ptr SHALL hold.
REQ-017 A broadcast already registered SHALL still be presented in the flush cycle.
REQ-018 With a single requester, that unit SHALL be granted in the same cycle regardless of ptr.
REQ-019 Any unit continuously requesting SHALL be granted within NREQ cycles (no starvation).
REQ-020 Simultaneous rst and flush: rst SHALL take priority.

Reset
REQ-021 On rst, ptr SHALL be set to 0 and cdb_valid, cdb_data, cdb_tag, cdb_src, perf_grant_cnt and perf_conflict_cnt SHALL be set to 0.
REQ-022 During a rst cycle, req_ready SHALL be all zeros.
REQ-023 A reset asserted mid-stream SHALL discard the pending broadcast; no transfer SHALL occur in the reset cycle.

Configuration
REQ-024 Macro CDB_PERF_CNT_EN defined:
- perf_grant_cnt SHALL increment per transfer.
- perf_conflict_cnt SHALL increment per cycle with two or more req_valid bits set and flush=0.
- Both counters SHALL saturate at 32'hFFFFFFFF.
- perf_clr SHALL zero both counters; perf_clr SHALL have priority over increment, rst SHALL have priority over perf_clr.
REQ-025 Macro CDB_PERF_CNT_EN undefined: the ports SHALL remain, both counters SHALL read constant 0, perf_clr SHALL be ignored, and no counter flops SHALL be inferred.

Verification
REQ-026 Reset, then req_valid=6'b000001, data=32'h0000_00AA, tag=4'h3: expect req_ready=6'b000001 the same cycle, then next cycle cdb_valid=1, cdb_data=32'hAA, cdb_tag=3, cdb_src=0.
REQ-027 All six units held valid for 12 cycles: expect grant order 0,1,2,3,4,5,0,...,5, with cdb_valid=1 for 12 consecutive cycles and each unit broadcast exactly twice.
REQ-028 ptr=4 with units 1 and 4 valid: expect 4 granted first, 1 next cycle, then ptr=2.
REQ-029 flush=1 with units 0-2 valid: expect req_ready=0 and cdb_valid=0 next cycle; after flush deasserts, unit 0 is granted (ptr unchanged).
REQ-030 With CDB_PERF_CNT_EN defined, 10 cycles of units 3 and 5 both valid: expect perf_grant_cnt=10 and perf_conflict_cnt=10; perf_clr then gives 0 and 0. Counter preloaded near 32'hFFFFFFFF: expect it to saturate.
REQ-031 rst asserted in the cycle after a grant: expect cdb_valid=0 and ptr=0, and the granted result is not broadcast.
